// File: rtl/rs_pkg.sv
// Shared Reed-Solomon constants for GF(256) encoder and syndrome decoder.
// Holds the field polynomial, parity count, generator taps and the encoder state type.
package rs_pkg;

    localparam int unsigned NumParity = 4;
    localparam logic [8:0]  FieldPoly = 9'h11D;

    // g(x) = x^4 + 15x^3 + 54x^2 + 120x + 64, roots 1, a, a^2, a^3
    localparam logic [7:0] GenC3 = 8'd15;
    localparam logic [7:0] GenC2 = 8'd54;
    localparam logic [7:0] GenC1 = 8'd120;
    localparam logic [7:0] GenC0 = 8'd64;

    typedef enum logic [1:0] {
        StIdle,
        StMsg,
        StPar
    } rs_state_e;

    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        gf_xtime = {a[6:0], 1'b0} ^ (a[7] ? FieldPoly[7:0] : 8'h00);
    endfunction

endpackage

// File: rtl/gf256_const_mult.sv
// Combinational GF(256) multiply by a fixed constant C (field polynomial from rs_pkg).
module gf256_const_mult
    import rs_pkg::*;
#(
    parameter logic [7:0] C = 8'h01
) (
    input  logic [7:0] din_i,
    output logic [7:0] dout_o
);

    // Shift-and-add over the constant's set bits; folds to an XOR network.
    always_comb begin
        logic [7:0] p;
        dout_o = 8'h00;
        p      = din_i;
        for (int i = 0; i < 8; i++) begin
            if (C[i]) begin
                dout_o = dout_o ^ p;
            end
            p = gf_xtime(p);
        end
    end

endmodule

// File: rtl/rs_encoder.sv
// Systematic RS(K+4, K) encoder over GF(256) with ready/valid streaming on both sides.
// Define RS_ENC_PARITY_INV_EN to emit parity symbols XORed with 0xFF.
module rs_encoder
    import rs_pkg::*;
#(
    parameter int unsigned K = 28
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_valid,
    output logic [7:0] o_data,
    output logic       o_last,
    input  logic       i_ready,
    output logic       o_busy
);

    localparam int unsigned     CntW    = (K > 1) ? $clog2(K) : 1;
    localparam logic [CntW-1:0] LastMsg = CntW'(K - 1);
    localparam int unsigned     ParW    = $clog2(NumParity);
    localparam logic [ParW-1:0] LastPar = ParW'(NumParity - 1);

`ifdef RS_ENC_PARITY_INV_EN
    localparam logic [7:0] ParMask = 8'hFF;
`else
    localparam logic [7:0] ParMask = 8'h00;
`endif

    rs_state_e       state_q, state_d;
    logic [7:0]      r3_q, r2_q, r1_q, r0_q;
    logic [7:0]      r3_d, r2_d, r1_d, r0_d;
    logic [CntW-1:0] msg_cnt_q, msg_cnt_d;
    logic [ParW-1:0] par_cnt_q, par_cnt_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            last_q, last_d;

    logic [7:0] fb, m3, m2, m1, m0;
    logic       out_free, accept;

    assign out_free = !valid_q || i_ready;
    assign o_ready  = (state_q == StMsg) && out_free;
    assign accept   = i_valid && o_ready;
    // Feedback is forced to zero outside MSG so parity readout is a plain shift.
    assign fb       = (state_q == StMsg) ? (i_data ^ r3_q) : 8'h00;

    gf256_const_mult #(.C(GenC3)) u_mult3 (.din_i(fb), .dout_o(m3));
    gf256_const_mult #(.C(GenC2)) u_mult2 (.din_i(fb), .dout_o(m2));
    gf256_const_mult #(.C(GenC1)) u_mult1 (.din_i(fb), .dout_o(m1));
    gf256_const_mult #(.C(GenC0)) u_mult0 (.din_i(fb), .dout_o(m0));

    always_comb begin
        state_d   = state_q;
        r3_d      = r3_q;
        r2_d      = r2_q;
        r1_d      = r1_q;
        r0_d      = r0_q;
        msg_cnt_d = msg_cnt_q;
        par_cnt_d = par_cnt_q;
        data_d    = data_q;
        valid_d   = valid_q;
        last_d    = last_q;

        if (out_free) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (i_start) begin
                    state_d   = StMsg;
                    r3_d      = 8'h00;
                    r2_d      = 8'h00;
                    r1_d      = 8'h00;
                    r0_d      = 8'h00;
                    msg_cnt_d = '0;
                    par_cnt_d = '0;
                end
            end
            StMsg: begin
                if (accept) begin
                    data_d  = i_data;
                    valid_d = 1'b1;
                    r3_d    = r2_q ^ m3;
                    r2_d    = r1_q ^ m2;
                    r1_d    = r0_q ^ m1;
                    r0_d    = m0;
                    if (msg_cnt_q == LastMsg) begin
                        state_d   = StPar;
                        msg_cnt_d = '0;
                    end else begin
                        msg_cnt_d = msg_cnt_q + CntW'(1);
                    end
                end
            end
            StPar: begin
                if (valid_q && last_q) begin
                    // Final parity leaves this cycle; a coincident start skips IDLE.
                    if (i_ready) begin
                        state_d = StIdle;
                        if (i_start) begin
                            state_d   = StMsg;
                            r3_d      = 8'h00;
                            r2_d      = 8'h00;
                            r1_d      = 8'h00;
                            r0_d      = 8'h00;
                            msg_cnt_d = '0;
                            par_cnt_d = '0;
                        end
                    end
                end else if (out_free) begin
                    data_d    = r3_q ^ ParMask;
                    valid_d   = 1'b1;
                    last_d    = (par_cnt_q == LastPar);
                    r3_d      = r2_q ^ m3;
                    r2_d      = r1_q ^ m2;
                    r1_d      = r0_q ^ m1;
                    r0_d      = m0;
                    par_cnt_d = par_cnt_q + ParW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= StIdle;
            r3_q      <= 8'h00;
            r2_q      <= 8'h00;
            r1_q      <= 8'h00;
            r0_q      <= 8'h00;
            msg_cnt_q <= '0;
            par_cnt_q <= '0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            r3_q      <= r3_d;
            r2_q      <= r2_d;
            r1_q      <= r1_d;
            r0_q      <= r0_d;
            msg_cnt_q <= msg_cnt_d;
            par_cnt_q <= par_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
        end
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;
    assign o_last  = last_q;
    assign o_busy  = (state_q != StIdle) || valid_q;

endmodule
